// File: rtl/count_capture.sv
// rtl/count_capture.sv - overflow-epoch timestamp capture into a small FIFO
//
// Extends the upstream 8-bit counter value with an epoch that tracks its
// wraps. Each 0->1 transition of cap_req records {epoch, cnt_in} into a FIFO
// that a host drains with pop. A capture dropped because the FIFO was full
// sets the sticky ovr flag.
//
// Optional feature macro: COUNT_CAPTURE_MATCH_EN (registered compare-match
// pulse on {epoch, cnt_in} == cmp_val). Without it, match is tied to 0.
//
// Ports:
//   clk, rstb        clock, asynchronous active-low reset
//   cnt_in, carry_in  upstream count value and its one-cycle wrap pulse
//   up_in            upstream direction (1 = up, 0 = down)
//   cap_req          capture request level (rising edge captures)
//   pop              remove head entry when ts_valid
//   clr_ovr          clear the overrun flag
//   cmp_val          compare value for the match feature
//   ts_out           head timestamp {epoch, count}, 0 when empty
//   ts_valid, full, fill  FIFO status
//   ovr              sticky overrun flag
//   epoch            current overflow epoch
//   match            compare-match pulse
module count_capture #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rstb,
    input  logic [WIDTH-1:0]           cnt_in,
    input  logic                       carry_in,
    input  logic                       up_in,
    input  logic                       cap_req,
    input  logic                       pop,
    input  logic                       clr_ovr,
    input  logic [2*WIDTH-1:0]         cmp_val,
    output logic [2*WIDTH-1:0]         ts_out,
    output logic                       ts_valid,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     fill,
    output logic                       ovr,
    output logic [WIDTH-1:0]           epoch,
    output logic                       match
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               cap_q;

    logic cap_evt;
    logic do_push;
    logic do_pop;
    logic drop;

    assign ts_valid = (fill != '0);
    assign full     = (fill == FILL_MAX);

    assign cap_evt = cap_req & ~cap_q;
    // A pop on a full FIFO frees the slot the concurrent capture needs.
    assign do_push = cap_evt & (~full | pop);
    assign do_pop  = pop & ts_valid;
    assign drop    = cap_evt & full & ~pop;

    // Gating by ts_valid makes a flushed or drained FIFO read as 0 without
    // having to reset the storage array.
    assign ts_out = ts_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= {epoch, cnt_in};
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            epoch  <= '0;
            cap_q  <= 1'b1;    // cap_req held high through reset must not capture
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
            ovr    <= 1'b0;
        end else begin
            cap_q <= cap_req;

            if (carry_in) begin
                epoch <= up_in ? epoch + WIDTH'(1) : epoch - WIDTH'(1);
            end

            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end

            case ({do_push, do_pop})
                2'b10:   fill <= fill + FW'(1);
                2'b01:   fill <= fill - FW'(1);
                default: fill <= fill;
            endcase

            if (drop) begin
                ovr <= 1'b1;
            end else if (clr_ovr) begin
                ovr <= 1'b0;
            end
        end
    end

`ifdef COUNT_CAPTURE_MATCH_EN
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            match <= 1'b0;
        end else begin
            match <= ({epoch, cnt_in} == cmp_val);
        end
    end
`else
    logic unused_cmp;
    assign unused_cmp = ^cmp_val;
    assign match      = 1'b0;
`endif

endmodule

// File: tb/tb_count_capture.sv
// tb/tb_count_capture.sv - scoreboard bench for count_capture
module tb_count_capture;

    logic        clk = 1'b0;
    logic        rstb;
    logic [7:0]  cnt_in;
    logic        carry_in;
    logic        up_in;
    logic        cap_req;
    logic        pop;
    logic        clr_ovr;
    logic [15:0] cmp_val;
    logic [15:0] ts_out;
    logic        ts_valid;
    logic        full;
    logic [2:0]  fill;
    logic        ovr;
    logic [7:0]  epoch;
    logic        match;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] exp_q[$];

`ifdef COUNT_CAPTURE_MATCH_EN
    localparam logic MATCH_ON = 1'b1;
`else
    localparam logic MATCH_ON = 1'b0;
`endif

    count_capture #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rstb(rstb), .cnt_in(cnt_in), .carry_in(carry_in),
        .up_in(up_in), .cap_req(cap_req), .pop(pop), .clr_ovr(clr_ovr),
        .cmp_val(cmp_val), .ts_out(ts_out), .ts_valid(ts_valid),
        .full(full), .fill(fill), .ovr(ovr), .epoch(epoch), .match(match)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow the same point.
    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: whenever the host pops a presented entry, compare against the
    // oldest expected timestamp.
    always @(negedge clk) begin
        if (rstb && pop && ts_valid) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL pop_unexpected: got %h expected none", ts_out);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (ts_out !== e) begin
                    miscompares++;
                    $display("FAIL pop_data: got %h expected %h", ts_out, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1);
    end

    initial begin
        rstb = 1'b0; cnt_in = 8'h00; carry_in = 1'b0; up_in = 1'b1;
        cap_req = 1'b1; pop = 1'b0; clr_ovr = 1'b0; cmp_val = 16'h0110;
        step(2);
        rstb = 1'b1;
        step(3);
        // Reset state; cap_req held high must not have captured
        check("rst_fill", 16'(fill), 16'd0);
        check("rst_valid", 16'(ts_valid), 16'd0);
        check("rst_full", 16'(full), 16'd0);
        check("rst_ovr", 16'(ovr), 16'd0);
        check("rst_epoch", 16'(epoch), 16'd0);
        check("rst_match", 16'(match), 16'd0);
        check("rst_ts", ts_out, 16'h0000);

        // Drop and raise: one capture of 0x0034
        cap_req = 1'b0; step();
        cnt_in = 8'h34; cap_req = 1'b1; exp_q.push_back(16'h0034); step();
        check("cap1_valid", 16'(ts_valid), 16'd1);
        check("cap1_fill", 16'(fill), 16'd1);
        check("cap1_ts", ts_out, 16'h0034);
        step();
        check("cap1_held_fill", 16'(fill), 16'd1);
        cap_req = 1'b0; pop = 1'b1; step(); pop = 1'b0;
        check("pop1_valid", 16'(ts_valid), 16'd0);

        // Epoch: +3, -2 -> 1; -1 -> 0; -1 -> 0xFF; +6 -> 0x05
        carry_in = 1'b1; up_in = 1'b1; step(3);
        check("epoch_up3", 16'(epoch), 16'd3);
        up_in = 1'b0; step(2);
        check("epoch_dn2", 16'(epoch), 16'd1);
        step(2);
        check("epoch_wrap_dn", 16'(epoch), 16'h00FF);
        up_in = 1'b1; step(6);
        check("epoch_wrap_up", 16'(epoch), 16'h0005);

        // Capture on the same edge as a carry takes the pre-update epoch
        cnt_in = 8'h00; cap_req = 1'b1; exp_q.push_back(16'h0500); step();
        carry_in = 1'b0; cap_req = 1'b0;
        check("carry_cap_epoch", 16'(epoch), 16'd6);
        check("carry_cap_ts", ts_out, 16'h0500);
        pop = 1'b1; step(); pop = 1'b0;

        // Five captures into a 4-deep FIFO: the fifth is dropped
        for (int i = 1; i <= 5; i++) begin
            cap_req = 1'b0; step();
            cnt_in = 8'(i); cap_req = 1'b1;
            if (i <= 4) exp_q.push_back({8'h06, 8'(i)});
            step();
        end
        check("ovf_full", 16'(full), 16'd1);
        check("ovf_fill", 16'(fill), 16'd4);
        check("ovf_ovr", 16'(ovr), 16'd1);

        // Capture plus pop while full: both succeed
        cap_req = 1'b0; step();
        cnt_in = 8'h06; cap_req = 1'b1; pop = 1'b1; exp_q.push_back(16'h0606); step();
        pop = 1'b0;
        check("fullpp_fill", 16'(fill), 16'd4);
        check("fullpp_ovr", 16'(ovr), 16'd1);

        clr_ovr = 1'b1; step(); clr_ovr = 1'b0;
        check("clr_ovr", 16'(ovr), 16'd0);

        // Drop and clear on the same edge: set wins
        cap_req = 1'b0; step();
        cap_req = 1'b1; clr_ovr = 1'b1; step(); clr_ovr = 1'b0;
        check("set_wins_ovr", 16'(ovr), 16'd1);
        check("set_wins_fill", 16'(fill), 16'd4);
        cap_req = 1'b0; clr_ovr = 1'b1; step(); clr_ovr = 1'b0;

        // Drain in order, then pop on empty is ignored
        pop = 1'b1; step(4);
        check("drain_valid", 16'(ts_valid), 16'd0);
        check("drain_ts", ts_out, 16'h0000);
        step();
        pop = 1'b0;
        check("empty_pop_fill", 16'(fill), 16'd0);

        // Capture and pop on empty: push succeeds
        cnt_in = 8'h77; cap_req = 1'b1; pop = 1'b1; exp_q.push_back(16'h0677); step();
        pop = 1'b0; cap_req = 1'b0;
        check("empty_pp_fill", 16'(fill), 16'd1);
        pop = 1'b1; step(); pop = 1'b0;

        // Compare match: bring epoch to 1, sweep cnt_in through 0x10
        carry_in = 1'b1; up_in = 1'b0; step(5); carry_in = 1'b0;
        check("match_epoch", 16'(epoch), 16'd1);
        cnt_in = 8'h0F; step();
        check("match_before", 16'(match), 16'd0);
        cnt_in = 8'h10; step();
        check("match_hit", 16'(match), 16'(MATCH_ON));
        cnt_in = 8'h11; step();
        check("match_after", 16'(match), 16'd0);

        // Asynchronous reset mid-operation flushes the FIFO
        cap_req = 1'b1; step(); cap_req = 1'b0;
        check("prereset_fill", 16'(fill), 16'd1);
        #2 rstb = 1'b0;
        #1;
        check("async_fill", 16'(fill), 16'd0);
        check("async_ts", ts_out, 16'h0000);
        check("async_epoch", 16'(epoch), 16'd0);
        step(); rstb = 1'b1; step();

        check("queue_empty", 16'(exp_q.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/count_capture.md
# count_capture

Timestamp capture stage placed directly downstream of the 8-bit preload up/down counter. Consumes the counter's `dout` and `carry` to keep an overflow epoch, forming a {epoch, count} timestamp. On each rising edge of an external capture request, the block pushes that timestamp into a small FIFO. A host drains the FIFO through a pop strobe; overruns are flagged sticky.

## Interface
- `WIDTH`, 8: width of the upstream count; timestamp is 2*WIDTH bits.
- `DEPTH`, 4: FIFO entries; power of two, minimum 2.
- `clk` in 1: single clock; all state updates on rising edge.
- `rstb` in 1: reset, asynchronous, active-low.
- `cnt_in` in WIDTH: upstream counter value (`dout`).
- `carry_in` in 1: upstream wrap pulse (`carry`), one cycle per wrap.
- `up_in` in 1: upstream direction, 1 = counting up, 0 = counting down.
- `cap_req` in 1: capture request, level; a 0→1 transition triggers a capture.
- `pop` in 1: removes the head entry when `ts_valid`=1.
- `clr_ovr` in 1: clears `ovr`.
- `cmp_val` in 2*WIDTH: compare value; used only with the match feature.
- `ts_out` out 2*WIDTH: head timestamp, {epoch, count}; 0 when empty.
- `ts_valid` out 1: FIFO not empty.
- `full` out 1: FIFO holds DEPTH entries.
- `fill` out log2(DEPTH)+1: number of entries held.
- `ovr` out 1: sticky flag; a capture was dropped.
- `epoch` out WIDTH: current overflow epoch.
- `match` out 1: compare-match pulse; constant 0 without the match feature.

## Operation
- Epoch:
  - When `carry_in`=1 and `up_in`=1, `epoch` increments.
  - When `carry_in`=1 and `up_in`=0, `epoch` decrements.
  - `epoch` wraps modulo 2^WIDTH in both directions.
  - When `carry_in`=0, `epoch` holds.
- Edge detect: a register `cap_q` holds the previous `cap_req`. A capture event occurs when `cap_req`=1 and `cap_q`=0.
- Timestamp: {`epoch`, `cnt_in`} as present at the edge where the event is detected. `epoch` is taken pre-update, even when `carry_in` is 1 on the same edge.
- Push rules:
  - Capture with FIFO not full: the entry is written at the write pointer and `fill` increments.
  - Capture with FIFO full and `pop`=0: the entry is dropped and `ovr` is set to 1.
  - Capture with FIFO full and `pop`=1: the pop and the push both succeed, `fill` stays DEPTH, and `ovr` is unchanged.
- Pop rules:
  - `pop` with `ts_valid`=1 advances the read pointer and decrements `fill`.
  - `pop` with FIFO empty is ignored.
  - Simultaneous push and pop on a non-empty, non-full FIFO leaves `fill` unchanged.
  - Capture and pop on an empty FIFO: the push succeeds and the pop is ignored, so `fill` becomes 1.
- `ovr`: cleared by `clr_ovr`. When `clr_ovr` and a drop occur on the same edge, the set wins.
- Pointers: width log2(DEPTH), wrapping naturally; full/empty are decided from `fill`.

## Timing
- Reset values: `epoch`=0, `fill`=0, `ts_valid`=0, `full`=0, `ovr`=0, `match`=0, `ts_out`=0, pointers=0.
- `cap_q` resets to 1, so a `cap_req` held high through reset does not produce a capture.
- Reset mid-operation flushes the FIFO immediately (asynchronous). Stored entries are lost and `ts_out` reads 0.
- Capture latency:
  - Event detected at edge N: `ts_valid`, `fill` and `full` update after edge N.
  - `ts_out` shows the entry from edge N onward, provided it is at the head.
- `ts_out` is driven from the FIFO read pointer; it changes only after a pop or a push into an empty FIFO.
- `epoch` updates after the edge on which `carry_in` is sampled high.
- Inputs are synchronous to `clk`; `cap_req` from an asynchronous source must be synchronized upstream of this block.

## Configuration
- Macro: `COUNT_CAPTURE_MATCH_EN`.
- With the macro defined:
  - `match` is registered.
  - `match` is 1 for exactly one cycle after any edge where {`epoch`, `cnt_in`} == `cmp_val`.
  - `match` stays 1 on consecutive edges while the equality holds.
- Without the macro: no compare logic is built, `match` is tied to 0, and `cmp_val` is unused.
- The port list is identical in both builds.

## Test plan
- Reset release with `cap_req`=1 held → no capture, `fill`=0, `ts_valid`=0; then drop to 0 and raise again → one entry.
- `cnt_in`=0x34, `epoch`=0, `cap_req` rising → `ts_out`=0x0034, `ts_valid`=1 after that edge; one `pop` → `ts_valid`=0.
- Three `carry_in` pulses with `up_in`=1, then two with `up_in`=0 → `epoch`=1. Decrement from 0 → `epoch`=0xFF.
- Capture coincident with `carry_in`, `epoch`=0x05, `cnt_in`=0x00 → stored 0x0500, and `epoch` becomes 6 afterwards.
- Five captures without pop (DEPTH=4) → `full`=1, `fill`=4, `ovr`=1; the first four timestamps pop out in order.
  - Capture plus `pop` while full → no drop.
  - `clr_ovr` → `ovr`=0.
- Match build, `cmp_val`=0x0110, count to epoch 1 / cnt 0x10 → `match` high exactly one cycle. Non-match build → `match` always 0.
